// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix engine: semiring modes, FSM states, identity/saturation helpers.
// Build option SYSTOLIC_TROPICAL_EN enables the min-plus semiring for mode 3.
package systolic_pkg;

  localparam logic [1:0] MODE_BOOL = 2'd0;
  localparam logic [1:0] MODE_WRAP = 2'd1;
  localparam logic [1:0] MODE_SAT  = 2'd2;
  localparam logic [1:0] MODE_TROP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_READ
  } state_t;

`ifdef SYSTOLIC_TROPICAL_EN
  localparam bit TROP_EN = 1'b1;
`else
  localparam bit TROP_EN = 1'b0;
`endif

  // Unsigned add clamped to the largest acc_w-bit value; the 33-bit sum never wraps.
  function automatic logic [31:0] sat_add(input logic [31:0] x, input logic [31:0] y,
                                          input int unsigned acc_w);
    logic [32:0] sum;
    logic [31:0] max;
    sum = {1'b0, x} + {1'b0, y};
    max = 32'hFFFF_FFFF >> (32 - acc_w);
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

  function automatic logic [31:0] identity(input logic [1:0] mode, input int unsigned acc_w);
    return (TROP_EN && mode == MODE_TROP) ? (32'hFFFF_FFFF >> (32 - acc_w)) : 32'd0;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary cell: registered operand pass-through plus accumulator with a per-mode ALU.
// Build option SYSTOLIC_TROPICAL_EN selects min-plus for mode 3, otherwise mode 3 behaves as wrap.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_id,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     a_in,
  input  logic             a_vin,
  input  logic [W-1:0]     b_in,
  input  logic             b_vin,
  output logic [W-1:0]     a_out,
  output logic             a_vout,
  output logic [W-1:0]     b_out,
  output logic             b_vout,
  output logic [ACC_W-1:0] acc
);

  logic [31:0] a32, b32, acc32, prod, nxt, id;

  always_comb begin
    a32   = 32'(a_in);
    b32   = 32'(b_in);
    acc32 = 32'(acc);
    prod  = a32 * b32;
    id    = identity(mode, ACC_W);
    nxt   = acc32;
    case (mode)
      MODE_BOOL: nxt = acc32 | (a32 & b32);
      MODE_WRAP: nxt = acc32 + prod;
      MODE_SAT:  nxt = sat_add(acc32, prod, ACC_W);
`ifdef SYSTOLIC_TROPICAL_EN
      MODE_TROP: begin
        nxt = sat_add(a32, b32, ACC_W);
        if (acc32 < nxt) nxt = acc32;
      end
`else
      MODE_TROP: nxt = acc32 + prod;
`endif
      default:   nxt = acc32;
    endcase
  end

  generate
    if (ACC_W < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^{nxt[31:ACC_W], id[31:ACC_W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      a_out  <= '0;
      a_vout <= 1'b0;
      b_out  <= '0;
      b_vout <= 1'b0;
      acc    <= '0;
    end else begin
      a_out  <= a_in;
      a_vout <= a_vin;
      b_out  <= b_in;
      b_vout <= b_vin;
      if (load_id)
        acc <= id[ACC_W-1:0];
      else if (a_vin && b_vin)
        acc <= nxt[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/systolic_mm_array.sv
// N x N output-stationary systolic matrix engine with input skew network and row-wise readback.
// Build option SYSTOLIC_TROPICAL_EN enables the min-plus semiring (mode 3) in every PE.
module systolic_mm_array
  import systolic_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned W      = 4,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned KLEN_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [KLEN_W-1:0]  k_len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W-1:0]     in_a,
  input  logic [N*W-1:0]     in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*ACC_W-1:0] out_row,
  output logic               out_last
);

  localparam int unsigned RW = $clog2(N);
  localparam int unsigned DW = $clog2(2 * N);

  state_t            state, state_nx;
  logic [1:0]        mode_q, pe_mode;
  logic [KLEN_W-1:0] k_cnt;
  logic [DW-1:0]     d_cnt;
  logic [RW-1:0]     row;
  logic              accept, push, pop, last_push, load_id;

  assign accept    = (state == ST_IDLE) && start;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign last_push = push && (k_cnt == KLEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = (k_len != '0) ? ST_FEED : ST_READ;
      ST_FEED:  if (last_push) state_nx = ST_DRAIN;
      ST_DRAIN: if (d_cnt == '0) state_nx = ST_READ;
      ST_READ:  if (pop && row == RW'(N - 1)) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  logic [ACC_W-1:0] acc_g [N][N];

  always_comb begin
    busy      = (state != ST_IDLE);
    in_ready  = (state == ST_FEED);
    out_valid = (state == ST_READ);
    out_last  = (state == ST_READ) && (row == RW'(N - 1));
    load_id   = accept;
    // Identity is loaded in the start cycle, before mode_q holds the new mode.
    pe_mode   = accept ? mode : mode_q;
    out_row   = '0;
    if (state == ST_READ)
      for (int unsigned j = 0; j < N; j++)
        out_row[j*ACC_W +: ACC_W] = acc_g[row][j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= '0;
      k_cnt  <= '0;
      d_cnt  <= '0;
      row    <= '0;
    end else begin
      if (accept) begin
        mode_q <= mode;
        k_cnt  <= k_len;
        row    <= '0;
      end
      if (push) k_cnt <= k_cnt - KLEN_W'(1);
      if (last_push) d_cnt <= DW'(2 * N - 2);
      else if (state == ST_DRAIN && d_cnt != '0) d_cnt <= d_cnt - DW'(1);
      if (pop) row <= row + RW'(1);
    end
  end

  logic [W-1:0] a_e [N];
  logic [W-1:0] b_e [N];
  logic         va_e [N];
  logic         vb_e [N];

  // Row/column i is delayed by i cycles so slice k reaches PE(i,j) at one instant.
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_e[i]  = in_a[i*W +: W];
      assign va_e[i] = push;
      assign b_e[i]  = in_b[i*W +: W];
      assign vb_e[i] = push;
    end else begin : g_delay
      logic [W-1:0] da [i];
      logic [W-1:0] db [i];
      logic         va [i];
      logic         vb [i];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned k = 0; k < i; k++) begin
            da[k] <= '0;
            db[k] <= '0;
            va[k] <= 1'b0;
            vb[k] <= 1'b0;
          end
        end else begin
          da[0] <= push ? in_a[i*W +: W] : '0;
          db[0] <= push ? in_b[i*W +: W] : '0;
          va[0] <= push;
          vb[0] <= push;
          for (int unsigned k = 1; k < i; k++) begin
            da[k] <= da[k-1];
            db[k] <= db[k-1];
            va[k] <= va[k-1];
            vb[k] <= vb[k-1];
          end
        end
      end
      assign a_e[i]  = da[i-1];
      assign va_e[i] = va[i-1];
      assign b_e[i]  = db[i-1];
      assign vb_e[i] = vb[i-1];
    end
  end

  logic [W-1:0] a_h  [N][N+1];
  logic         va_h [N][N+1];
  logic [W-1:0] b_v  [N+1][N];
  logic         vb_v [N+1][N];
  logic         unused_edge [N];

  for (genvar i = 0; i < N; i++) begin : g_row
    assign a_h[i][0]      = a_e[i];
    assign va_h[i][0]     = va_e[i];
    assign b_v[0][i]      = b_e[i];
    assign vb_v[0][i]     = vb_e[i];
    assign unused_edge[i] = ^{a_h[i][N], va_h[i][N], b_v[N][i], vb_v[N][i]};
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(.W(W), .ACC_W(ACC_W)) u_pe (
        .clk    (clk),
        .reset  (reset),
        .load_id(load_id),
        .mode   (pe_mode),
        .a_in   (a_h[i][j]),
        .a_vin  (va_h[i][j]),
        .b_in   (b_v[i][j]),
        .b_vin  (vb_v[i][j]),
        .a_out  (a_h[i][j+1]),
        .a_vout (va_h[i][j+1]),
        .b_out  (b_v[i+1][j]),
        .b_vout (vb_v[i+1][j]),
        .acc    (acc_g[i][j])
      );
    end
  end

endmodule

// File: tb/tb_systolic_mm_array.sv
// Directed bench for systolic_mm_array: a 12-bit and an 8-bit accumulator instance run in lockstep.
module tb_systolic_mm_array;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     mode = '0;
  logic [7:0]     k_len = '0;
  logic           in_valid = 1'b0;
  logic [N*W-1:0] in_a = '0;
  logic [N*W-1:0] in_b = '0;
  logic           out_ready = 1'b0;

  logic            busy12, in_ready12, out_valid12, out_last12;
  logic [N*12-1:0] out_row12;
  logic            busy8, in_ready8, out_valid8, out_last8;
  logic [N*8-1:0]  out_row8;

  int total = 0;
  int bad = 0;

  logic [3:0] sa [4][4];
  logic [3:0] sb [4][4];
  int exp12 [4][4];
  int exp8  [4][4];
  bit chk8;
  int bt [4][4] = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, 11, 12}, '{13, 14, 15, 0}};

  always #5 clk = ~clk;

  systolic_mm_array #(.N(N), .W(W), .ACC_W(12), .KLEN_W(8)) dut12 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .k_len(k_len), .busy(busy12),
    .in_valid(in_valid), .in_ready(in_ready12), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid12), .out_ready(out_ready), .out_row(out_row12), .out_last(out_last12)
  );

  systolic_mm_array #(.N(N), .W(W), .ACC_W(8), .KLEN_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .k_len(k_len), .busy(busy8),
    .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid8), .out_ready(out_ready), .out_row(out_row8), .out_last(out_last8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [3:0] av, input logic [3:0] bv);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) begin
        sa[k][i] = av;
        sb[k][i] = bv;
      end
  endtask

  task automatic set_exp(input int v12, input int v8);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) begin
        exp12[r][j] = v12;
        exp8[r][j]  = v8;
      end
  endtask

  task automatic setup_test1();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) begin
        sa[k][i] = (i == k) ? 4'd1 : 4'd0;
        sb[k][i] = 4'(bt[k][i]);
        exp12[k][i] = bt[k][i];
        exp8[k][i]  = bt[k][i];
      end
    chk8 = 1'b1;
  endtask

  task automatic check_row(input int r);
    check("out_valid_row", 32'(out_valid12), 32'd1);
    check("out_last", 32'(out_last12), (r == N - 1) ? 32'd1 : 32'd0);
    for (int j = 0; j < N; j++) begin
      check("row12", 32'(out_row12[j*12 +: 12]), 32'(exp12[r][j]));
      if (chk8) check("row8", 32'(out_row8[j*8 +: 8]), 32'(exp8[r][j]));
    end
  endtask

  task automatic run_op(input logic [1:0] m, input int k, input bit toggle, input bit stall,
                        input bit pulse);
    int idx;
    int cyc;
    bit hs;
    mode  = m;
    k_len = 8'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy12), 32'd1);
    idx = 0;
    cyc = 0;
    while (idx < k && cyc < 200) begin
      in_valid = toggle ? (cyc % 2 == 1) : 1'b1;
      start    = pulse && (idx == 1);
      mode     = pulse ? 2'd2 : m;
      for (int i = 0; i < N; i++) begin
        in_a[i*W +: W] = sa[idx][i];
        in_b[i*W +: W] = sb[idx][i];
      end
      hs = in_valid && in_ready12;
      tick();
      cyc++;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("feed_done", 32'(idx), 32'(k));
    check("in_ready_low", 32'(in_ready12), 32'd0);
    cyc = 0;
    while (!out_valid12 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("out_valid_seen", 32'(out_valid12), 32'd1);
    for (int r = 0; r < N; r++) begin
      if (stall && r == 1) begin
        out_ready = 1'b0;
        repeat (5) begin
          check_row(r);
          tick();
        end
      end
      out_ready = 1'b1;
      check_row(r);
      tick();
    end
    out_ready = 1'b0;
    check("busy_end", 32'(busy12), 32'd0);
    check("out_valid_end", 32'(out_valid12), 32'd0);
  endtask

  initial begin
    chk8 = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy12), 32'd0);
    check("rst_in_ready", 32'(in_ready12), 32'd0);
    check("rst_out_valid", 32'(out_valid12), 32'd0);
    check("rst_out_last", 32'(out_last12), 32'd0);
    check("rst_out_row12", 32'(out_row12 != '0), 32'd0);
    check("rst_out_row8", 32'(out_row8 != '0), 32'd0);
    reset = 1'b0;
    tick();

    // identity A reproduces B in both widths
    setup_test1();
    run_op(2'd1, 4, 1'b0, 1'b0, 1'b0);

    // all-15 operands, k=4: 900 wraps to 132 in 8 bits, saturates to 255
    fill(4'd15, 4'd15);
    set_exp(900, 132);
    run_op(2'd1, 4, 1'b0, 1'b0, 1'b0);
    set_exp(900, 255);
    run_op(2'd2, 4, 1'b0, 1'b0, 1'b0);

    // boolean: (0011&0110)|(1000&1000) = 1010
    fill(4'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      sa[0][i] = 4'b0011; sb[0][i] = 4'b0110;
      sa[1][i] = 4'b1000; sb[1][i] = 4'b1000;
    end
    set_exp(10, 10);
    run_op(2'd0, 2, 1'b0, 1'b0, 1'b0);

    // min-plus: min(3+4, 5+1) = 6; wrap alias gives 3*4+5*1 = 17
    for (int i = 0; i < 4; i++) begin
      sa[0][i] = 4'd3; sb[0][i] = 4'd4;
      sa[1][i] = 4'd5; sb[1][i] = 4'd1;
    end
`ifdef SYSTOLIC_TROPICAL_EN
    set_exp(6, 6);
`else
    set_exp(17, 17);
`endif
    run_op(2'd3, 2, 1'b0, 1'b0, 1'b0);

    // k_len = 0 leaves the identity in place
`ifdef SYSTOLIC_TROPICAL_EN
    set_exp(4095, 255);
`else
    set_exp(0, 0);
`endif
    run_op(2'd3, 0, 1'b0, 1'b0, 1'b0);
    set_exp(0, 0);
    run_op(2'd1, 0, 1'b0, 1'b0, 1'b0);

    // mode 3 with all-15 operands: min-plus gives 30, wrap alias gives 900 / 132
    fill(4'd15, 4'd15);
`ifdef SYSTOLIC_TROPICAL_EN
    set_exp(30, 30);
`else
    set_exp(900, 132);
`endif
    run_op(2'd3, 4, 1'b0, 1'b0, 1'b0);

    // input bubbles and output stall on row 1
    setup_test1();
    run_op(2'd1, 4, 1'b1, 1'b1, 1'b0);

    // start pulsed while feeding is ignored
    setup_test1();
    run_op(2'd1, 4, 1'b0, 1'b0, 1'b1);

    // reset in the middle of FEED
    fill(4'd15, 4'd15);
    mode = 2'd1; k_len = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_a = '1; in_b = '1;
    repeat (2) tick();
    check("feed_before_reset", 32'(in_ready12), 32'd1);
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    check("midrst_busy", 32'(busy12), 32'd0);
    check("midrst_in_ready", 32'(in_ready12), 32'd0);
    check("midrst_out_valid", 32'(out_valid12), 32'd0);
    reset = 1'b0;
    tick();
    setup_test1();
    run_op(2'd1, 4, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
